// File: rtl/alarm_pkg.sv
// Shared types and widths for the alarm sequencer.
package alarm_pkg;

  localparam int unsigned HH_W   = 5;
  localparam int unsigned MM_W   = 6;
  localparam int unsigned RCNT_W = 8;
  localparam int unsigned MCNT_W = 4;
  localparam int unsigned SCNT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2,
    HOLD   = 2'd3
  } state_e;

endpackage

// File: rtl/rise_detect.sv
// One-cycle rising-edge detector with a configurable history reset value.
module rise_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic ck,
  input  logic reset_n,
  input  logic d,
  output logic rise
);

  logic hist_q;

  // History flop; resetting to 1 suppresses an edge from a level held through reset
  always_ff @(posedge ck or negedge reset_n) begin
    if (!reset_n) hist_q <= RST_VAL;
    else          hist_q <= d;
  end

  assign rise = d & ~hist_q;

endmodule

// File: rtl/alarm_control.sv
// Alarm sequencer: trigger on time match, 1 s on/off buzzer, snooze, timeout.
module alarm_control
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic       ck,
  input  logic       reset_n,
  input  logic       alarm_en,
  input  logic       setting,
  input  logic [4:0] clk_hh,
  input  logic [5:0] clk_mm,
  input  logic [4:0] al_hh,
  input  logic [5:0] al_mm,
  input  logic       sec_tick,
  input  logic       min_tick,
  input  logic       snooze,
  input  logic       stop,
  output logic       ring,
  output logic       snoozed,
  output logic       ringing
);

  state_e              state_q, state_d;
  logic [RCNT_W-1:0]   ring_cnt_q, ring_cnt_d;
  logic [MCNT_W-1:0]   min_cnt_q, min_cnt_d;
  logic [SCNT_W-1:0]   snz_cnt_q, snz_cnt_d;
  logic                beep_q, beep_d;
  logic                ring_q, snoozed_q, ringing_q;

  logic                match_c;
  logic                snz_rise_c, stop_rise_c;
  logic [RCNT_W-1:0]   ring_inc_c;
  logic [MCNT_W-1:0]   min_inc_c;

  rise_detect #(.RST_VAL(1'b1)) u_snz_rise (
    .ck      (ck),
    .reset_n (reset_n),
    .d       (snooze),
    .rise    (snz_rise_c)
  );

  rise_detect #(.RST_VAL(1'b1)) u_stop_rise (
    .ck      (ck),
    .reset_n (reset_n),
    .d       (stop),
    .rise    (stop_rise_c)
  );

  assign match_c = alarm_en & (clk_hh == al_hh) & (clk_mm == al_mm);

  // Saturating increments; the FSM leaves the state before these can wrap
  assign ring_inc_c = (ring_cnt_q == '1) ? ring_cnt_q : ring_cnt_q + RCNT_W'(1);
  assign min_inc_c  = (min_cnt_q  == '1) ? min_cnt_q  : min_cnt_q  + MCNT_W'(1);

  // Next-state and counter updates; stop outranks tick-driven updates
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    min_cnt_d  = min_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    beep_d     = beep_q;

    case (state_q)
      IDLE: begin
        if (match_c && !setting) begin
          state_d    = RING;
          ring_cnt_d = '0;
          beep_d     = 1'b1;
        end
      end

      RING: begin
        if (!alarm_en) begin
          state_d    = IDLE;
          ring_cnt_d = '0;
          min_cnt_d  = '0;
          snz_cnt_d  = '0;
          beep_d     = 1'b0;
        end else if (stop_rise_c) begin
          state_d = HOLD;
        end else if (snz_rise_c && (snz_cnt_q < SCNT_W'(MAX_SNOOZE))) begin
          state_d   = SNOOZE;
          snz_cnt_d = snz_cnt_q + SCNT_W'(1);
          min_cnt_d = '0;
        end else if (sec_tick) begin
          ring_cnt_d = ring_inc_c;
          beep_d     = ~beep_q;
          if (ring_inc_c == RCNT_W'(RING_SEC)) state_d = HOLD;
        end
      end

      SNOOZE: begin
        if (!alarm_en) begin
          state_d    = IDLE;
          ring_cnt_d = '0;
          min_cnt_d  = '0;
          snz_cnt_d  = '0;
          beep_d     = 1'b0;
        end else if (stop_rise_c) begin
          state_d = HOLD;
        end else if (min_tick) begin
          min_cnt_d = min_inc_c;
          if (min_inc_c == MCNT_W'(SNOOZE_MIN)) begin
            state_d    = RING;
            ring_cnt_d = '0;
            beep_d     = 1'b1;
          end
        end
      end

      HOLD: begin
        // Wait out the matching minute so the alarm cannot retrigger
        if (!match_c || !alarm_en) begin
          state_d   = IDLE;
          snz_cnt_d = '0;
        end
      end

      default: begin
        state_d    = IDLE;
        ring_cnt_d = '0;
        min_cnt_d  = '0;
        snz_cnt_d  = '0;
        beep_d     = 1'b0;
      end
    endcase
  end

  // State, counters and outputs registered from the next state
  always_ff @(posedge ck or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ring_cnt_q <= '0;
      min_cnt_q  <= '0;
      snz_cnt_q  <= '0;
      beep_q     <= 1'b0;
      ring_q     <= 1'b0;
      snoozed_q  <= 1'b0;
      ringing_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      min_cnt_q  <= min_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      beep_q     <= beep_d;
      ring_q     <= (state_d == RING) & beep_d;
      snoozed_q  <= (state_d == SNOOZE);
      ringing_q  <= (state_d == RING);
    end
  end

  assign ring    = ring_q;
  assign snoozed = snoozed_q;
  assign ringing = ringing_q;

endmodule
